control_sequencer: RTL and testbench

//  Hardwired multi-cycle control unit driving the CPU datapath strobes (Rin/Rout, PCout, MARin, MDRin, IRin, op_code, ...).

---
 rtl/control_sequencer_pkg.sv | 77 +++++++
 rtl/control_sequencer_reg_select_decoder.sv | 13 +
 rtl/control_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for control_sequencer: FSM states, opcode map and opcode classes.
// The PAUSE state exists only when CU_SINGLE_STEP_EN is defined.
package control_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_RST,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_T7,
      ST_HALT
`ifdef CU_SINGLE_STEP_EN
      , ST_PAUSE
`endif
   } state_t;

   typedef enum logic [3:0] {
      CL_LD,
      CL_LDI,
      CL_ST,
      CL_ALU3,
      CL_IMM,
      CL_MULDIV,
      CL_UNARY,
      CL_NOP,
      CL_HALT,
      CL_ILL
   } cls_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_ADD = OP_ADD;

   function automatic cls_t op_class(input logic [4:0] op);
      cls_t c;
      case (op)
         OP_LD:                          c = CL_LD;
         OP_LDI:                         c = CL_LDI;
         OP_ST:                          c = CL_ST;
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
         OP_SHL:                         c = CL_ALU3;
         OP_ADDI, OP_ANDI, OP_ORI:       c = CL_IMM;
         OP_MUL, OP_DIV:                 c = CL_MULDIV;
         OP_NEG, OP_NOT:                 c = CL_UNARY;
         OP_NOP:                         c = CL_NOP;
         OP_HALT:                        c = CL_HALT;
         default:                        c = CL_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// 4-bit register field to 16-bit one-hot select; all zeros when not enabled.
module reg_select_decoder (
   input  logic [3:0]  i_field,
   input  logic        i_en,
   output logic [15:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_field] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0-T2, per-opcode execute steps, memory wait with timeout.
// Optional CU_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TW          = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   input  logic        run,
`ifdef CU_SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic [15:0] rin,
   output logic [15:0] rout,
   output logic        BAout,
   output logic        PCout,
   output logic        pc_increment,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        read,
   output logic        write,
   output logic        IRin,
   output logic        RYin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic        Cout,
   output logic [4:0]  op_code,
   output logic        halted,
   output logic        illegal,
   output logic        bus_err
);

   state_t      r_state;
   state_t      w_next;
   state_t      w_done;
   logic [TW-1:0] r_cnt;
   logic        r_bus_err;
   logic [4:0]  w_op;
   logic [3:0]  w_ra, w_rb, w_rc;
   cls_t        w_cls;
   logic        w_wait, w_stall, w_timeout;
   logic        w_rin_en, w_rout_en;
   logic [3:0]  w_rout_sel;
   logic        w_unused_imm;

   assign w_op         = ir[31:27];
   assign w_ra         = ir[26:23];
   assign w_rb         = ir[22:19];
   assign w_rc         = ir[18:15];
   assign w_unused_imm = ^ir[14:0];
   assign w_cls        = op_class(w_op);

   assign w_wait    = (r_state == ST_T1)
                    || ((r_state == ST_T6) && (w_cls == CL_LD))
                    || ((r_state == ST_T7) && (w_cls == CL_ST));
   assign w_stall   = w_wait && !mem_ready;
   // Counter holds stalls already seen, so the limit is hit on the MEM_TIMEOUT-th stalled cycle.
   assign w_timeout = w_stall && (r_cnt == TW'(MEM_TIMEOUT - 1));

`ifdef CU_SINGLE_STEP_EN
   logic r_step_d;
   logic w_step_rise;
   assign w_step_rise = step && !r_step_d;
   assign w_done      = ST_PAUSE;
`else
   assign w_done      = ST_T0;
`endif

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state   <= ST_RST;
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
`ifdef CU_SINGLE_STEP_EN
         r_step_d  <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_stall && !w_timeout) ? r_cnt + 1'b1 : '0;
         if (w_timeout) r_bus_err <= 1'b1;
`ifdef CU_SINGLE_STEP_EN
         r_step_d <= step;
`endif
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RST:  if (run) w_next = ST_T0;
         ST_T0:   w_next = ST_T1;
         ST_T1: begin
            if (mem_ready)      w_next = ST_T2;
            else if (w_timeout) w_next = ST_HALT;
         end
         ST_T2: begin
            case (w_cls)
               CL_NOP:  w_next = w_done;
               CL_HALT: w_next = ST_HALT;
               default: w_next = ST_T3;
            endcase
         end
         ST_T3:   w_next = (w_cls == CL_ILL) ? w_done : ST_T4;
         ST_T4:   w_next = (w_cls == CL_UNARY) ? w_done : ST_T5;
         ST_T5: begin
            if ((w_cls == CL_LD) || (w_cls == CL_ST) || (w_cls == CL_MULDIV)) w_next = ST_T6;
            else                                                            w_next = w_done;
         end
         ST_T6: begin
            case (w_cls)
               CL_ST: w_next = ST_T7;
               CL_LD: begin
                  if (mem_ready)      w_next = ST_T7;
                  else if (w_timeout) w_next = ST_HALT;
               end
               default: w_next = w_done;
            endcase
         end
         ST_T7: begin
            if (w_cls == CL_ST) begin
               if (mem_ready)      w_next = w_done;
               else if (w_timeout) w_next = ST_HALT;
            end else begin
               w_next = w_done;
            end
         end
         ST_HALT: w_next = ST_HALT;
`ifdef CU_SINGLE_STEP_EN
         ST_PAUSE: if (w_step_rise) w_next = ST_T0;
`endif
         default: w_next = ST_RST;
      endcase
   end

   always_comb begin
      w_rin_en     = 1'b0;
      w_rout_en    = 1'b0;
      w_rout_sel   = w_rb;
      BAout        = 1'b0;
      PCout        = 1'b0;
      pc_increment = 1'b0;
      MARin        = 1'b0;
      MDRin        = 1'b0;
      MDRout       = 1'b0;
      read         = 1'b0;
      write        = 1'b0;
      IRin         = 1'b0;
      RYin         = 1'b0;
      Zlowin       = 1'b0;
      Zhighin      = 1'b0;
      Zlowout      = 1'b0;
      Zhighout     = 1'b0;
      HIin         = 1'b0;
      LOin         = 1'b0;
      Cout         = 1'b0;
      op_code      = '0;
      illegal      = 1'b0;
      case (r_state)
         ST_T0: begin
            PCout        = 1'b1;
            MARin        = 1'b1;
            pc_increment = 1'b1;
         end
         ST_T1: begin
            read  = 1'b1;
            MDRin = mem_ready;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            case (w_cls)
               CL_ALU3, CL_IMM: begin
                  w_rout_en = 1'b1;
                  RYin      = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  w_rout_en = 1'b1;
                  BAout     = 1'b1;
                  RYin      = 1'b1;
               end
               CL_MULDIV: begin
                  w_rout_en  = 1'b1;
                  w_rout_sel = w_ra;
                  RYin       = 1'b1;
               end
               CL_UNARY: begin
                  w_rout_en = 1'b1;
                  op_code   = w_op;
                  Zlowin    = 1'b1;
               end
               CL_ILL:  illegal = 1'b1;
               default: ;
            endcase
         end
         ST_T4: begin
            case (w_cls)
               CL_ALU3: begin
                  w_rout_en  = 1'b1;
                  w_rout_sel = w_rc;
                  op_code    = w_op;
                  Zlowin     = 1'b1;
               end
               CL_IMM: begin
                  Cout    = 1'b1;
                  op_code = w_op;
                  Zlowin  = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  Cout    = 1'b1;
                  op_code = ALU_ADD;
                  Zlowin  = 1'b1;
               end
               CL_MULDIV: begin
                  w_rout_en = 1'b1;
                  op_code   = w_op;
                  Zlowin    = 1'b1;
                  Zhighin   = 1'b1;
               end
               CL_UNARY: begin
                  Zlowout  = 1'b1;
                  w_rin_en = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (w_cls)
               CL_ALU3, CL_IMM, CL_LDI: begin
                  Zlowout  = 1'b1;
                  w_rin_en = 1'b1;
               end
               CL_LD, CL_ST: begin
                  Zlowout = 1'b1;
                  MARin   = 1'b1;
               end
               CL_MULDIV: begin
                  Zlowout = 1'b1;
                  LOin    = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (w_cls)
               CL_LD: begin
                  read  = 1'b1;
                  MDRin = mem_ready;
               end
               CL_ST: begin
                  w_rout_en  = 1'b1;
                  w_rout_sel = w_ra;
                  MDRin      = 1'b1;
               end
               CL_MULDIV: begin
                  Zhighout = 1'b1;
                  HIin     = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (w_cls)
               CL_LD: begin
                  MDRout   = 1'b1;
                  w_rin_en = 1'b1;
               end
               CL_ST:   write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign halted  = (r_state == ST_HALT);
   assign bus_err = r_bus_err;

   reg_select_decoder u_rin_dec (
      .i_field  (w_ra),
      .i_en     (w_rin_en),
      .o_onehot (rin)
   );

   reg_select_decoder u_rout_dec (
      .i_field  (w_rout_sel),
      .i_en     (w_rout_en),
      .o_onehot (rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus pushes per-cycle expected strobes, a monitor compares.
// Handles the optional CU_SINGLE_STEP_EN build by stepping out of PAUSE after each instruction.
module tb_control_sequencer;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic BAout, PCout, pc_increment, MARin, MDRin, MDRout, read, write;
      logic IRin, RYin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout;
      logic [4:0] op_code;
      logic halted, illegal, bus_err;
   } outs_t;

   typedef struct {
      string nm;
      outs_t e;
   } item_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ir = '0;
   logic        mem_ready = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic [15:0] rin, rout;
   logic        BAout, PCout, pc_increment, MARin, MDRin, MDRout, read, write;
   logic        IRin, RYin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout;
   logic [4:0]  op_code;
   logic        halted, illegal, bus_err;

   item_t q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   control_sequencer #(.MEM_TIMEOUT(16), .TW(4)) dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .run(run),
`ifdef CU_SINGLE_STEP_EN
      .step(step),
`endif
      .rin(rin), .rout(rout), .BAout(BAout), .PCout(PCout), .pc_increment(pc_increment),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .read(read), .write(write),
      .IRin(IRin), .RYin(RYin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
      .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Cout(Cout), .op_code(op_code),
      .halted(halted), .illegal(illegal), .bus_err(bus_err)
   );

   always @(negedge clk) begin
      item_t it;
      outs_t act;
      if (q.size() > 0) begin
         it  = q.pop_front();
         act = {rin, rout, BAout, PCout, pc_increment, MARin, MDRin, MDRout, read, write,
                IRin, RYin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout,
                op_code, halted, illegal, bus_err};
         n_chk++;
         if (act !== it.e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", it.nm, act, it.e);
         end
      end
   end

   task automatic cyc(input string nm, input logic mr, input outs_t e);
      item_t it;
      mem_ready = mr;
      it.nm = nm;
      it.e  = e;
      q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string nm);
      outs_t e;
      e = '0; e.PCout = 1'b1; e.MARin = 1'b1; e.pc_increment = 1'b1;
      cyc({nm, "_t0"}, 1'b1, e);
      e = '0; e.read = 1'b1; e.MDRin = 1'b1;
      cyc({nm, "_t1"}, 1'b1, e);
      e = '0; e.MDRout = 1'b1; e.IRin = 1'b1;
      cyc({nm, "_t2"}, 1'b1, e);
   endtask

   task automatic end_instr(input string nm);
`ifdef CU_SINGLE_STEP_EN
      cyc({nm, "_pause"}, 1'b1, '0);
      step = 1'b1;
      cyc({nm, "_pause_step"}, 1'b1, '0);
      step = 1'b0;
`else
      step = 1'b0;
      if (nm.len() == 0) $display("empty instruction tag");
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      outs_t e;
      @(posedge clk); #1;
      cyc("rst0", 1'b0, '0);
      cyc("rst1", 1'b1, '0);
      clr = 1'b1;
      cyc("rst_idle_run0", 1'b1, '0);
      run = 1'b1;
      cyc("rst_run", 1'b1, '0);

      // add R5,R2,R4
      ir = 32'h1A920000;
      fetch("add");
      e = '0; e.rout = 16'h0004; e.RYin = 1'b1;                                 cyc("add_t3", 1'b1, e);
      e = '0; e.rout = 16'h0010; e.op_code = 5'b00011; e.Zlowin = 1'b1;         cyc("add_t4", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.rin = 16'h0020;                               cyc("add_t5", 1'b1, e);
      end_instr("add");

      // ld R1,0x54(R0) with a 3-cycle memory delay
      ir = {5'b00000, 4'd1, 4'd0, 4'd0, 15'h0054};
      fetch("ld");
      e = '0; e.rout = 16'h0001; e.BAout = 1'b1; e.RYin = 1'b1;                 cyc("ld_t3", 1'b1, e);
      e = '0; e.Cout = 1'b1; e.op_code = 5'b00011; e.Zlowin = 1'b1;             cyc("ld_t4", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.MARin = 1'b1;                                 cyc("ld_t5", 1'b1, e);
      e = '0; e.read = 1'b1;
      for (int i = 0; i < 3; i++) cyc("ld_t6_stall", 1'b0, e);
      e = '0; e.read = 1'b1; e.MDRin = 1'b1;                                    cyc("ld_t6_ack", 1'b1, e);
      e = '0; e.MDRout = 1'b1; e.rin = 16'h0002;                                cyc("ld_t7", 1'b1, e);
      end_instr("ld");

      // st R6,0x10(R2) with a 2-cycle write delay
      ir = {5'b00010, 4'd6, 4'd2, 4'd0, 15'h0010};
      fetch("st");
      e = '0; e.rout = 16'h0004; e.BAout = 1'b1; e.RYin = 1'b1;                 cyc("st_t3", 1'b1, e);
      e = '0; e.Cout = 1'b1; e.op_code = 5'b00011; e.Zlowin = 1'b1;             cyc("st_t4", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.MARin = 1'b1;                                 cyc("st_t5", 1'b1, e);
      e = '0; e.rout = 16'h0040; e.MDRin = 1'b1;                                cyc("st_t6", 1'b0, e);
      e = '0; e.write = 1'b1;
      cyc("st_t7_stall", 1'b0, e);
      cyc("st_t7_stall", 1'b0, e);
      cyc("st_t7_ack", 1'b1, e);
      end_instr("st");

      // mul R3,R1
      ir = {5'b10000, 4'd3, 4'd1, 4'd0, 15'h0};
      fetch("mul");
      e = '0; e.rout = 16'h0008; e.RYin = 1'b1;                                 cyc("mul_t3", 1'b1, e);
      e = '0; e.rout = 16'h0002; e.op_code = 5'b10000; e.Zlowin = 1'b1; e.Zhighin = 1'b1;
      cyc("mul_t4", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.LOin = 1'b1;                                  cyc("mul_t5", 1'b1, e);
      e = '0; e.Zhighout = 1'b1; e.HIin = 1'b1;                                 cyc("mul_t6", 1'b1, e);
      end_instr("mul");

      // neg R4,R7
      ir = {5'b10001, 4'd4, 4'd7, 4'd0, 15'h0};
      fetch("neg");
      e = '0; e.rout = 16'h0080; e.op_code = 5'b10001; e.Zlowin = 1'b1;         cyc("neg_t3", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.rin = 16'h0010;                               cyc("neg_t4", 1'b1, e);
      end_instr("neg");

      // addi R2,R3,5
      ir = {5'b01100, 4'd2, 4'd3, 4'd0, 15'h0005};
      fetch("addi");
      e = '0; e.rout = 16'h0008; e.RYin = 1'b1;                                 cyc("addi_t3", 1'b1, e);
      e = '0; e.Cout = 1'b1; e.op_code = 5'b01100; e.Zlowin = 1'b1;             cyc("addi_t4", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.rin = 16'h0004;                               cyc("addi_t5", 1'b1, e);
      end_instr("addi");

      // sub R15,R0,R15: field extremes 0 and 15
      ir = {5'b00100, 4'd15, 4'd0, 4'd15, 15'h0};
      fetch("sub");
      e = '0; e.rout = 16'h0001; e.RYin = 1'b1;                                 cyc("sub_t3", 1'b1, e);
      e = '0; e.rout = 16'h8000; e.op_code = 5'b00100; e.Zlowin = 1'b1;         cyc("sub_t4", 1'b1, e);
      e = '0; e.Zlowout = 1'b1; e.rin = 16'h8000;                               cyc("sub_t5", 1'b1, e);
      end_instr("sub");

      ir = {5'b11010, 27'h0};
      fetch("nop");
      end_instr("nop");

      ir = {5'b11111, 27'h0};
      fetch("ill");
      e = '0; e.illegal = 1'b1;                                                 cyc("ill_t3", 1'b1, e);
      end_instr("ill");

      // fetch ack on the 16th wait cycle must not raise a bus error
      ir = {5'b11010, 27'h0};
      e = '0; e.PCout = 1'b1; e.MARin = 1'b1; e.pc_increment = 1'b1;            cyc("lim_t0_mr_ignored", 1'b0, e);
      e = '0; e.read = 1'b1;
      for (int i = 0; i < 15; i++) cyc("lim_t1_stall", 1'b0, e);
      e = '0; e.read = 1'b1; e.MDRin = 1'b1;                                    cyc("lim_t1_ack16", 1'b1, e);
      e = '0; e.MDRout = 1'b1; e.IRin = 1'b1;                                   cyc("lim_t2", 1'b1, e);
      end_instr("lim");

      // mul interrupted by reset in T4
      ir = {5'b10000, 4'd3, 4'd1, 4'd0, 15'h0};
      fetch("mulr");
      e = '0; e.rout = 16'h0008; e.RYin = 1'b1;                                 cyc("mulr_t3", 1'b1, e);
      clr = 1'b0;
      e = '0; e.rout = 16'h0002; e.op_code = 5'b10000; e.Zlowin = 1'b1; e.Zhighin = 1'b1;
      cyc("mulr_t4_clr", 1'b1, e);
      cyc("mulr_after_clr", 1'b1, '0);
      clr = 1'b1;
      cyc("rst_run2", 1'b1, '0);

      ir = {5'b11011, 27'h0};
      fetch("halt");
      e = '0; e.halted = 1'b1;
      cyc("halt_h0", 1'b0, e);
      cyc("halt_h1", 1'b1, e);
      clr = 1'b0;
      cyc("halt_clr", 1'b1, e);
      cyc("rst_after_halt", 1'b1, '0);
      clr = 1'b1;
      cyc("rst_run3", 1'b1, '0);

      // 16 stalled fetch cycles: bus error and halt
      ir = {5'b11010, 27'h0};
      e = '0; e.PCout = 1'b1; e.MARin = 1'b1; e.pc_increment = 1'b1;            cyc("to_t0", 1'b1, e);
      e = '0; e.read = 1'b1;
      for (int i = 0; i < 16; i++) cyc("to_t1_stall", 1'b0, e);
      e = '0; e.halted = 1'b1; e.bus_err = 1'b1;
      cyc("to_halt0", 1'b1, e);
      cyc("to_halt1", 1'b0, e);
      clr = 1'b0;
      cyc("to_clr", 1'b1, e);
      cyc("to_rst_clears_err", 1'b1, '0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
